// File: rtl/snn_motor_decoder.sv
// snn_motor_decoder
//
// Takes the two output-neuron spike trains of the SNN core and turns them into
// a drive command and a PWM pair for the motor driver. Spikes are counted over
// fixed windows of enabled cycles. The latched rates produce a candidate
// command (STOP / FORWARD / LEFT / RIGHT) with a deadband. A debounce FSM then
// applies a new non-STOP command only after it has been the candidate for two
// windows in a row. STOP is always applied at once.
//
// Ports
//   clk       system clock, everything on the rising edge
//   rst       synchronous active-high reset
//   en        global enable; while low all state holds, spikes are ignored,
//             PWM outputs are 0 and win_done is 0
//   spike_in  [0] left output-neuron spike, [1] right output-neuron spike
//   pwm_l     left motor PWM
//   pwm_r     right motor PWM
//   dir_code  applied command: 00 STOP, 01 FORWARD, 10 LEFT, 11 RIGHT
//   rate_l    left spike count of the last completed window
//   rate_r    right spike count of the last completed window
//   win_done  one-cycle pulse when rate_l/rate_r have just been updated
module snn_motor_decoder #(
    parameter int WIN_LEN      = 256,
    parameter int CNT_W        = 9,
    parameter int MIN_RATE     = 4,
    parameter int DEADBAND     = 2,
    parameter int PWM_W        = 8,
    parameter int BASE_DUTY    = 160,
    parameter int TURN_DUTY_HI = 200,
    parameter int TURN_DUTY_LO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       spike_in,
    output logic             pwm_l,
    output logic             pwm_r,
    output logic [1:0]       dir_code,
    output logic [CNT_W-1:0] rate_l,
    output logic [CNT_W-1:0] rate_r,
    output logic             win_done
);

    localparam int WCNT_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    // Rate comparisons use one extra bit so rate + DEADBAND cannot wrap.
    localparam logic [CNT_W:0]    MIN_EXT   = (CNT_W + 1)'(MIN_RATE);
    localparam logic [CNT_W:0]    DB_EXT    = (CNT_W + 1)'(DEADBAND);
    localparam logic [PWM_W-1:0]  DUTY_BASE = PWM_W'(BASE_DUTY);
    localparam logic [PWM_W-1:0]  DUTY_HI   = PWM_W'(TURN_DUTY_HI);
    localparam logic [PWM_W-1:0]  DUTY_LO   = PWM_W'(TURN_DUTY_LO);
    localparam logic [PWM_W-1:0]  PCNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_FWD   = 2'b01,
        ST_LEFT  = 2'b10,
        ST_RIGHT = 2'b11
    } dir_t;

    // ------------------------------------------------------------------
    // Window counter
    // ------------------------------------------------------------------
    logic [WCNT_W-1:0] wcnt_reg;
    logic              last_cycle;
    logic              win_done_reg;

    assign last_cycle = en && (wcnt_reg == WCNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_reg <= '0;
        end else if (en) begin
            if (last_cycle) begin
                wcnt_reg <= '0;
            end else begin
                wcnt_reg <= wcnt_reg + 1'b1;
            end
        end
    end

    // The pulse register holds through en-low cycles so the pending window
    // evaluation is never lost; the visible pulse is gated by en.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_done_reg <= 1'b0;
        end else if (en) begin
            win_done_reg <= last_cycle;
        end
    end

    assign win_done = win_done_reg && en;

    // ------------------------------------------------------------------
    // Per-channel saturating spike counters and latched rates
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] rate_reg;

            // cnt_next includes this cycle's spike, so the last window cycle
            // is counted when the rate is latched.
            always_comb begin
                cnt_next = cnt_reg;
                if (spike_in[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg  <= '0;
                    rate_reg <= '0;
                end else if (en) begin
                    if (last_cycle) begin
                        rate_reg <= cnt_next;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg  <= cnt_next;
                    end
                end
            end
        end
    endgenerate

    assign rate_l = g_chan[0].rate_reg;
    assign rate_r = g_chan[1].rate_reg;

    // ------------------------------------------------------------------
    // Candidate decision from the latched rates
    // ------------------------------------------------------------------
    logic [CNT_W:0] rl_ext;
    logic [CNT_W:0] rr_ext;
    dir_t           cand;

    always_comb begin
        rl_ext = {1'b0, rate_l};
        rr_ext = {1'b0, rate_r};
        if ((rl_ext < MIN_EXT) && (rr_ext < MIN_EXT)) begin
            cand = ST_STOP;
        end else if (rl_ext > (rr_ext + DB_EXT)) begin
            cand = ST_LEFT;
        end else if (rr_ext > (rl_ext + DB_EXT)) begin
            cand = ST_RIGHT;
        end else begin
            cand = ST_FWD;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: evaluated on the first enabled cycle after a window
    // closes, so state/dir_code change two cycles after the last window cycle.
    // ------------------------------------------------------------------
    dir_t state_reg;
    dir_t state_next;
    dir_t pending_reg;
    dir_t pending_next;
    logic eval;

    assign eval = en && win_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_STOP;
            pending_reg <= ST_STOP;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        if (eval) begin
            pending_next = cand;
            if (cand == ST_STOP) begin
                state_next = ST_STOP;
            end else if (cand == pending_reg) begin
                state_next = cand;
            end
        end
    end

    assign dir_code = state_reg;

    // ------------------------------------------------------------------
    // PWM generation
    // ------------------------------------------------------------------
    logic [PWM_W-1:0] pcnt_reg;
    logic [PWM_W-1:0] duty_l_next;
    logic [PWM_W-1:0] duty_r_next;
    logic [PWM_W-1:0] duty_l_reg;
    logic [PWM_W-1:0] duty_r_reg;

    always_comb begin
        duty_l_next = '0;
        duty_r_next = '0;
        case (state_reg)
            ST_FWD: begin
                duty_l_next = DUTY_BASE;
                duty_r_next = DUTY_BASE;
            end
            ST_LEFT: begin
                duty_l_next = DUTY_LO;
                duty_r_next = DUTY_HI;
            end
            ST_RIGHT: begin
                duty_l_next = DUTY_HI;
                duty_r_next = DUTY_LO;
            end
            default: begin
                duty_l_next = '0;
                duty_r_next = '0;
            end
        endcase
    end

    // Active duties only change at a period boundary, so a running period is
    // never cut short or stretched by a command change.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg   <= '0;
            duty_l_reg <= '0;
            duty_r_reg <= '0;
        end else if (en) begin
            pcnt_reg <= pcnt_reg + 1'b1;
            if (pcnt_reg == PCNT_LAST) begin
                duty_l_reg <= duty_l_next;
                duty_r_reg <= duty_r_next;
            end
        end
    end

    assign pwm_l = en && (pcnt_reg < duty_l_reg);
    assign pwm_r = en && (pcnt_reg < duty_r_reg);

endmodule

// File: tb/tb_snn_motor_decoder.sv
// Testbench for snn_motor_decoder.
// Drives one 256-enabled-cycle window per table row. In row N the bench checks:
// - the win_done pulse and the rates of row N-1;
// - dir_code after row N-1;
// - the PWM high counts of the current period. Window and PWM period are both
//   256 cycles and start together, so these come from the command decided two
//   windows earlier.
// A second instance with CNT_W=6 sees the same stimulus and checks saturation.
module tb_snn_motor_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] spike_in;
    logic       pwm_l, pwm_r, win_done;
    logic [1:0] dir_code;
    logic [8:0] rate_l, rate_r;
    logic       s_pwm_l, s_pwm_r, s_win_done;
    logic [1:0] s_dir_code;
    logic [5:0] s_rate_l, s_rate_r;

    int n_checks = 0;
    int n_fail   = 0;

    snn_motor_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .spike_in (spike_in),
        .pwm_l    (pwm_l),
        .pwm_r    (pwm_r),
        .dir_code (dir_code),
        .rate_l   (rate_l),
        .rate_r   (rate_r),
        .win_done (win_done)
    );

    snn_motor_decoder #(.CNT_W(6)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .spike_in (spike_in),
        .pwm_l    (s_pwm_l),
        .pwm_r    (s_pwm_r),
        .dir_code (s_dir_code),
        .rate_l   (s_rate_l),
        .rate_r   (s_rate_r),
        .win_done (s_win_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         nl;        // left spikes in the first nl enabled cycles
        int         nr;        // right spikes in the first nr enabled cycles
        int         gap_start; // cycle index at which en drops
        int         gap_len;   // en-low cycles (0 = none)
        int         exp_rl;
        int         exp_rr;
        logic [1:0] exp_dir;   // dir_code after this window is evaluated
    } vec_t;

    localparam int NROWS = 17;
    vec_t tbl [NROWS];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int duty_of(input logic [1:0] d, input bit right);
        case (d)
            2'b01:   return 160;
            2'b10:   return right ? 200 : 64;
            2'b11:   return right ? 64 : 200;
            default: return 0;
        endcase
    endfunction

    function automatic int sat63(input int v);
        return (v > 63) ? 63 : v;
    endfunction

    // Entered at posedge+1; leaves at posedge+1 of the next window.
    task automatic run_window(input int row);
        int         en_idx  = 0;
        int         cyc     = 0;
        int         wd_hits = 0;
        int         hl      = 0;
        int         hr      = 0;
        int         gap_pwm = 0;
        int         gs      = tbl[row].gap_start;
        int         gl      = tbl[row].gap_len;
        bit         in_gap;
        logic [1:0] old_dir;
        while (en_idx < 256) begin
            in_gap = (gl > 0) && (cyc >= gs) && (cyc < gs + gl);
            en = !in_gap;
            if (in_gap) spike_in = 2'b11;
            else        spike_in = {en_idx < tbl[row].nr, en_idx < tbl[row].nl};
            #1;
            if (win_done) wd_hits++;
            if (in_gap) begin
                gap_pwm += int'(pwm_l | pwm_r);
            end else begin
                hl += int'(pwm_l);
                hr += int'(pwm_r);
            end
            if (row > 0 && cyc == 0) begin
                check($sformatf("row%0d win_done_T+1", row - 1), int'(win_done), 1);
                check($sformatf("row%0d rate_l", row - 1), int'(rate_l), tbl[row - 1].exp_rl);
                check($sformatf("row%0d rate_r", row - 1), int'(rate_r), tbl[row - 1].exp_rr);
                check($sformatf("row%0d sat_rate_l", row - 1), int'(s_rate_l), sat63(tbl[row - 1].exp_rl));
                check($sformatf("row%0d sat_rate_r", row - 1), int'(s_rate_r), sat63(tbl[row - 1].exp_rr));
            end
            if (row > 0 && cyc == 1) begin
                check($sformatf("row%0d dir_code_T+2", row - 1), int'(dir_code), int'(tbl[row - 1].exp_dir));
            end
            if (!in_gap) en_idx++;
            cyc++;
            @(posedge clk);
            #1;
        end
        check($sformatf("row%0d win_done_count", row), wd_hits, (row > 0) ? 1 : 0);
        old_dir = (row >= 2) ? tbl[row - 2].exp_dir : 2'b00;
        check($sformatf("row%0d pwm_l_high", row), hl, duty_of(old_dir, 1'b0));
        check($sformatf("row%0d pwm_r_high", row), hr, duty_of(old_dir, 1'b1));
        if (gl > 0) check($sformatf("row%0d pwm_during_gap", row), gap_pwm, 0);
    endtask

    initial begin
        //            nl   nr  gs  gl  rl   rr   dir
        tbl[0]  = '{  0,   0,  0,  0,   0,   0, 2'b00};
        tbl[1]  = '{256,  64,  0,  0, 256,  64, 2'b00}; // LEFT pending
        tbl[2]  = '{256,  64,  0,  0, 256,  64, 2'b10}; // LEFT applied
        tbl[3]  = '{ 50,  48,  0,  0,  50,  48, 2'b10}; // FORWARD pending
        tbl[4]  = '{ 50,  48,  0,  0,  50,  48, 2'b01};
        tbl[5]  = '{ 51,  48,  0,  0,  51,  48, 2'b01}; // just outside deadband
        tbl[6]  = '{ 51,  48,  0,  0,  51,  48, 2'b10};
        tbl[7]  = '{ 50,  48,  0,  0,  50,  48, 2'b10};
        tbl[8]  = '{ 50,  48,  0,  0,  50,  48, 2'b01};
        tbl[9]  = '{  3,   3,  0,  0,   3,   3, 2'b00}; // STOP is immediate
        tbl[10] = '{ 48,  51,  0,  0,  48,  51, 2'b00}; // RIGHT pending
        tbl[11] = '{ 48,  51,  0,  0,  48,  51, 2'b11};
        tbl[12] = '{  4,   0,  0,  0,   4,   0, 2'b11}; // rate at MIN_RATE is not STOP
        tbl[13] = '{  3,   0,  0,  0,   3,   0, 2'b00};
        tbl[14] = '{100,  30, 100, 10, 100,  30, 2'b00}; // en gap mid-window
        tbl[15] = '{100,  30,  0,  0, 100,  30, 2'b10};
        tbl[16] = '{  0,   0,  0,  0,   0,   0, 2'b00};

        rst = 1'b1;
        en = 1'b0;
        spike_in = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            en = 1'b1;
            spike_in = (i % 2 == 0) ? 2'b11 : 2'b01;
            #1;
            check($sformatf("reset%0d pwm_dir_wd", i), int'({pwm_l, pwm_r, dir_code, win_done}), 0);
            check($sformatf("reset%0d rates", i), int'({rate_l, rate_r}), 0);
        end
        rst = 1'b0;

        for (int r = 0; r < NROWS; r++) begin
            run_window(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_motor_decoder.md
# snn_motor_decoder

Downstream stage of the SNN controller: consumes the two output-neuron spike trains (bit 0 = Left, bit 1 = Right), counts spikes over fixed windows, decides a drive command with deadband and two-window debouncing, and produces glitch-free PWM for the left and right motors. It sits between the SNN core and the motor driver pins.

## Interface
- WIN_LEN, 256, enabled cycles per counting window (≥2)
- CNT_W, 9, spike counter and rate width; counters saturate at 2^CNT_W−1
- MIN_RATE, 4, a window where both rates are below this decides STOP
- DEADBAND, 2, maximum rate difference still decided as FORWARD
- PWM_W, 8, PWM counter width; period is 2^PWM_W cycles
- BASE_DUTY, 160, duty on both motors in FORWARD
- TURN_DUTY_HI, 200, duty on the outer motor in a turn
- TURN_DUTY_LO, 64, duty on the inner motor in a turn
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable, same as the SNN core's
- spike_in  in  2  [0] Left output spike, [1] Right output spike, one cycle per spike
- pwm_l  out  1  left motor PWM
- pwm_r  out  1  right motor PWM
- dir_code  out  2  applied command: 00 STOP, 01 FORWARD, 10 LEFT, 11 RIGHT
- rate_l  out  CNT_W  left spike count of last completed window
- rate_r  out  CNT_W  right spike count of last completed window
- win_done  out  1  one-cycle pulse: rate_l/rate_r just updated

## Operation
- Reset: all counters, rates, duties, pending and state cleared; dir_code=00, pwm_l=pwm_r=0, win_done=0.
- en low: window counter, spike counters, PWM counter, state all hold; spike_in ignored; pwm_l/pwm_r forced 0; win_done 0.
- Window counter wcnt runs 0..WIN_LEN−1 on enabled cycles, wraps to 0.
- Spike counters: +1 per enabled cycle with the corresponding spike_in bit high, saturating.
- Last window cycle (wcnt=WIN_LEN−1, en=1): that cycle's spikes are included; rate_l/rate_r load the final counts; counters clear to 0 (not counting a phantom); win_done pulses.
- Candidate decision from the latched rates, compared at CNT_W+1 bits unsigned:
  - STOP if rate_l<MIN_RATE and rate_r<MIN_RATE
  - LEFT if rate_l > rate_r+DEADBAND
  - RIGHT if rate_r > rate_l+DEADBAND
  - else FORWARD
- Debounce FSM (states STOP, FORWARD, LEFT, RIGHT; register pending, reset STOP), evaluated once per window:
  - cand=STOP → state STOP immediately
  - cand≠STOP and cand=pending → state=cand
  - otherwise state holds; pending<=cand always
- Duty per state: STOP 0/0; FORWARD BASE/BASE; LEFT l=TURN_DUTY_LO, r=TURN_DUTY_HI; RIGHT l=TURN_DUTY_HI, r=TURN_DUTY_LO.
- PWM: free-running pcnt (PWM_W bits) on enabled cycles; pwm_x=(pcnt<duty_x_active). Active duties reload from state only on enabled cycles where pcnt=2^PWM_W−1, so a period is never truncated.

## Timing
- T = last window cycle. T+1: rate_l/rate_r valid, win_done=1 for exactly one cycle. T+2: pending and state/dir_code updated.
- New duty takes effect at the first PWM period starting after T+2; pwm latency ≤ 2^PWM_W+2 cycles from T.
- Window length counts enabled cycles only; each en-low cycle delays win_done by one cycle.
- rst mid-window discards partial counts; the next window starts at the first enabled cycle after rst releases.
- Simultaneous spikes on both bits count in both counters in the same cycle.

## Test plan
- Reset: rst high 3 cycles with spikes toggling → all outputs 0; release with en=1, no spikes → win_done at the 257th cycle, rates 0, dir_code stays 00.
- Turn debounce: spike_in[0] every cycle, spike_in[1] every 4th, two windows → window 1 rates 256/64, dir_code 00; window 2 dir_code=10 at T+2; next PWM period pwm_l high 64/256, pwm_r high 200/256.
- Deadband: rates 50/48 for two windows → FORWARD, duty 160/160; then 51/48 twice → LEFT only after the second window.
- STOP immediacy: from FORWARD, one window with rates 3/3 → dir_code 00 at T+2, both PWM 0 from the next period.
- Saturation: CNT_W=6, 256 left spikes → rate_l=63, no wrap.
- en gap: drop en for 10 cycles mid-window → counts and PWM hold, pwm outputs 0, win_done exactly 10 cycles late, rates unchanged vs. the no-gap run.
